// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle instruction sequencer for the XM-23 datapath.
// It steps each instruction through FETCH -> PCINC -> DECODE -> EXEC1, with
// optional EXEC2 (BL, SWAP) or MEMW (LD/ST/LDR/STR) steps. It drives one-cycle
// enables to the register file, ALU, sign extender and byte-manip unit, and
// runs a req/ack handshake with memory. Any memory wait that reaches the
// timeout sends it to a sticky FAULT state.
// Ports:
//   clock, reset                 clock, async active-high reset
//   op, dst, srccon, rc, wb      decoded instruction fields
//   code_result                  branch condition for the current op
//   mem_ack                      memory completion
//   mem_req, mem_wr, mem_byte    memory request, direction, byte/word
//   ir_load, id_en, alu_en, sxt_en, bm_en      unit enables
//   psw_update, psw_set, psw_clr               PSW control
//   alu_op, sxt_bit                            ALU function, sign-extend bit
//   alu_rdst, alu_rsrc, dbus_rdst, dbus_rsrc   register selects
//   instr_done, fault                          done strobe, sticky timeout
module cpu_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned RNUM_W      = 5,
    parameter int unsigned PC_RNUM     = 7,
    parameter int unsigned LR_RNUM     = 5,
    parameter int unsigned TMP_RNUM    = 16,
    parameter int unsigned CONST2_RNUM = 10,
    parameter int unsigned TMO_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        dst,
    input  logic [2:0]        srccon,
    input  logic              rc,
    input  logic              wb,
    input  logic              code_result,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_wr,
    output logic              mem_byte,
    output logic              ir_load,
    output logic              id_en,
    output logic              alu_en,
    output logic              sxt_en,
    output logic              bm_en,
    output logic              psw_update,
    output logic              psw_set,
    output logic              psw_clr,
    output logic [5:0]        alu_op,
    output logic [3:0]        sxt_bit,
    output logic [RNUM_W-1:0] alu_rdst,
    output logic [RNUM_W-1:0] alu_rsrc,
    output logic [RNUM_W-1:0] dbus_rdst,
    output logic [RNUM_W-1:0] dbus_rsrc,
    output logic              instr_done,
    output logic              fault
);

    // The PSW masks need at least 5 data bits, and TMP must be addressable.
    if (DATA_W < 5 || TMP_RNUM >= (2 ** RNUM_W)) begin : g_param_check
        $error("cpu_sequencer: DATA_W or RNUM_W too small");
    end

    localparam logic [RNUM_W-1:0] RegPc  = RNUM_W'(PC_RNUM);
    localparam logic [RNUM_W-1:0] RegLr  = RNUM_W'(LR_RNUM);
    localparam logic [RNUM_W-1:0] RegTmp = RNUM_W'(TMP_RNUM);
    localparam logic [RNUM_W-1:0] RegC2  = RNUM_W'(CONST2_RNUM);
    // The counter shows 2**TMO_W-2 during the (2**TMO_W-1)th waiting cycle.
    localparam logic [TMO_W-1:0]  TmoLast = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        StFetch, StPcInc, StDecode, StExec1, StExec2, StMemW, StFault
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [RNUM_W-1:0] reg_dst, reg_src;
    logic              is_branch, is_alu, is_bm, is_mem, is_store, is_rel;
    logic [4:0]        alu_idx;

    // Constant-table sources sit at register numbers 8..15.
    assign reg_dst = RNUM_W'(dst);
    assign reg_src = rc ? RNUM_W'({1'b1, srccon}) : RNUM_W'(srccon);

    assign is_branch = (op >= 7'd1) && (op <= 7'd8);
    assign is_alu    = ((op >= 7'd9) && (op <= 7'd20)) || (op == 7'd23) || (op == 7'd24);
    assign is_bm     = (op == 7'd25) || ((op >= 7'd34) && (op <= 7'd37));
    assign is_store  = (op == 7'd33) || (op == 7'd39);
    assign is_rel    = (op == 7'd38) || (op == 7'd39);
    assign is_mem    = (op == 7'd32) || is_store || (op == 7'd38);
    // ALU functions are packed pairwise (word, byte); ops 21/22 leave a gap.
    assign alu_idx   = (op <= 7'd20) ? 5'(op - 7'd9) : 5'(op - 7'd11);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_byte   = 1'b0;
        ir_load    = 1'b0;
        id_en      = 1'b0;
        alu_en     = 1'b0;
        sxt_en     = 1'b0;
        bm_en      = 1'b0;
        psw_update = 1'b0;
        psw_set    = 1'b0;
        psw_clr    = 1'b0;
        alu_op     = '0;
        sxt_bit    = '0;
        alu_rdst   = '0;
        alu_rsrc   = '0;
        dbus_rdst  = '0;
        dbus_rsrc  = '0;
        instr_done = 1'b0;
        fault      = 1'b0;

        // Outputs are forced low while reset is held, even mid-transaction.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    dbus_rsrc = RegPc;
                    if (mem_ack) begin
                        ir_load = 1'b1;
                        tmo_d   = '0;
                        state_d = StPcInc;
                    end else if (tmo_q == TmoLast) begin
                        state_d = StFault;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                StPcInc: begin
                    alu_en     = 1'b1;
                    alu_rdst   = RegPc;
                    dbus_rdst  = RegPc;
                    alu_rsrc   = RegC2;
                    psw_update = 1'b1;
                    state_d    = StDecode;
                end
                StDecode: begin
                    id_en   = 1'b1;
                    state_d = StExec1;
                end
                StExec1: begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                    if (op == 7'd0) begin
                        // BL: save return address, PC update in EXEC2
                        dbus_rsrc  = RegPc;
                        dbus_rdst  = RegLr;
                        instr_done = 1'b0;
                        state_d    = StExec2;
                    end else if (is_branch) begin
                        if (code_result) begin
                            alu_en     = 1'b1;
                            sxt_en     = 1'b1;
                            sxt_bit    = 4'd10;
                            alu_rdst   = RegPc;
                            psw_update = 1'b1;
                        end
                    end else if (is_alu) begin
                        alu_en   = 1'b1;
                        alu_op   = {alu_idx, wb};
                        alu_rdst = reg_dst;
                        alu_rsrc = reg_src;
                    end else if (op == 7'd21) begin
                        dbus_rsrc = reg_src;
                        dbus_rdst = reg_dst;
                    end else if (op == 7'd22) begin
                        dbus_rsrc  = reg_src;
                        dbus_rdst  = RegTmp;
                        instr_done = 1'b0;
                        state_d    = StExec2;
                    end else if (is_bm) begin
                        bm_en     = 1'b1;
                        dbus_rsrc = reg_src;
                        dbus_rdst = reg_dst;
                    end else if (op == 7'd26) begin
                        sxt_en    = 1'b1;
                        sxt_bit   = 4'd7;
                        dbus_rsrc = reg_dst;
                        dbus_rdst = reg_dst;
                    end else if (op == 7'd29) begin
                        psw_set = 1'b1;
                    end else if (op == 7'd30) begin
                        psw_clr = 1'b1;
                    end else if (is_mem) begin
                        // Effective address lands in TMP; stores address through dst.
                        alu_en     = 1'b1;
                        alu_rdst   = RegTmp;
                        alu_rsrc   = is_store ? reg_dst : reg_src;
                        psw_update = 1'b1;
                        if (is_rel) begin
                            sxt_en  = 1'b1;
                            sxt_bit = 4'd6;
                        end
                        instr_done = 1'b0;
                        state_d    = StMemW;
                    end
                end
                StExec2: begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                    if (op == 7'd0) begin
                        alu_en     = 1'b1;
                        sxt_en     = 1'b1;
                        sxt_bit    = 4'd13;
                        alu_rdst   = RegPc;
                        psw_update = 1'b1;
                    end else begin
                        dbus_rsrc = RegTmp;
                        dbus_rdst = reg_dst;
                    end
                end
                StMemW: begin
                    mem_req  = 1'b1;
                    mem_wr   = is_store;
                    mem_byte = wb;
                    if (is_store) begin
                        dbus_rsrc = reg_src;
                    end
                    if (mem_ack) begin
                        if (!is_store) begin
                            dbus_rdst = reg_dst;
                        end
                        instr_done = 1'b1;
                        tmo_d      = '0;
                        state_d    = StFetch;
                    end else if (tmo_q == TmoLast) begin
                        state_d = StFault;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                StFault: begin
                    fault = 1'b1;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, randomized
// instructions against a cycle-list reference model, and hand-written
// reset / slow-memory / timeout sequences.
module tb_cpu_sequencer;

    localparam logic [4:0] PC  = 5'd7;
    localparam logic [4:0] LR  = 5'd5;
    localparam logic [4:0] TMP = 5'd16;
    localparam logic [4:0] C2  = 5'd10;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] dst, srccon;
    logic       rc, wb, code_result, mem_ack;
    logic       mem_req, mem_wr, mem_byte, ir_load, id_en, alu_en, sxt_en, bm_en;
    logic       psw_update, psw_set, psw_clr, instr_done, fault;
    logic [5:0] alu_op;
    logic [3:0] sxt_bit;
    logic [4:0] alu_rdst, alu_rsrc, dbus_rdst, dbus_rsrc;

    always #5 clock = ~clock;

    cpu_sequencer dut (
        .clock(clock), .reset(reset), .op(op), .dst(dst), .srccon(srccon), .rc(rc), .wb(wb),
        .code_result(code_result), .mem_ack(mem_ack), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_byte(mem_byte), .ir_load(ir_load), .id_en(id_en), .alu_en(alu_en),
        .sxt_en(sxt_en), .bm_en(bm_en), .psw_update(psw_update), .psw_set(psw_set),
        .psw_clr(psw_clr), .alu_op(alu_op), .sxt_bit(sxt_bit), .alu_rdst(alu_rdst),
        .alu_rsrc(alu_rsrc), .dbus_rdst(dbus_rdst), .dbus_rsrc(dbus_rsrc),
        .instr_done(instr_done), .fault(fault)
    );

    typedef struct packed {
        logic       mem_req, mem_wr, mem_byte, ir_load, id_en, alu_en, sxt_en, bm_en;
        logic       psw_update, psw_set, psw_clr;
        logic [5:0] alu_op;
        logic [3:0] sxt_bit;
        logic [4:0] alu_rdst, alu_rsrc, dbus_rdst, dbus_rsrc;
        logic       instr_done, fault;
    } outs_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] dst, src;
        logic       rc, wb, cr;
    } instr_t;

    typedef struct {
        instr_t     ins;
        int         len;
        logic       alu_en;
        logic [5:0] alu_op;
        logic [3:0] sxt_bit;
        logic [4:0] dbus_rdst;
        logic       mem_wr;
    } vec_t;

    int    checks = 0;
    int    passed = 0;
    outs_t exp_q[$];
    bit    ack_q[$];
    vec_t  vecs[$];

    function automatic outs_t snap();
        outs_t o;
        o.mem_req = mem_req;       o.mem_wr = mem_wr;       o.mem_byte = mem_byte;
        o.ir_load = ir_load;       o.id_en = id_en;         o.alu_en = alu_en;
        o.sxt_en = sxt_en;         o.bm_en = bm_en;         o.psw_update = psw_update;
        o.psw_set = psw_set;       o.psw_clr = psw_clr;     o.alu_op = alu_op;
        o.sxt_bit = sxt_bit;       o.alu_rdst = alu_rdst;   o.alu_rsrc = alu_rsrc;
        o.dbus_rdst = dbus_rdst;   o.dbus_rsrc = dbus_rsrc; o.instr_done = instr_done;
        o.fault = fault;
        return o;
    endfunction

    task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    task automatic check_outs(input string name, input outs_t act, input outs_t req);
        check_bits(name, 64'(act), 64'(req));
    endtask

    function automatic outs_t fetch_o(bit ack);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.dbus_rsrc = PC;
        o.ir_load = ack;
        return o;
    endfunction

    // ---------------- reference model: list of expected cycles ----------------
    function automatic logic [4:0] src_of(instr_t t);
        return t.rc ? 5'(8 + int'(t.src)) : {2'b00, t.src};
    endfunction

    // ALU function number: position in the ALU opcode list, times 2, plus wb.
    function automatic int alu_index(int o);
        int lst[14] = '{9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 23, 24};
        for (int i = 0; i < 14; i++) if (lst[i] == o) return i;
        return -1;
    endfunction

    task automatic push(input outs_t o, input bit a);
        exp_q.push_back(o);
        ack_q.push_back(a);
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic build(input instr_t t, input int fw, input int mw);
        outs_t o;
        int    opi = int'(t.op);
        int    k = alu_index(opi);
        logic [4:0] d = {2'b00, t.dst};
        bit    st = (opi == 33 || opi == 39);
        exp_q.delete();
        ack_q.delete();
        for (int i = 0; i <= fw; i++) push(fetch_o(i == fw), i == fw);
        o = '0; o.alu_en = 1; o.alu_rdst = PC; o.dbus_rdst = PC; o.alu_rsrc = C2;
        o.psw_update = 1; push(o, rnd());
        o = '0; o.id_en = 1; push(o, rnd());
        o = '0;
        if (opi == 0) begin
            o.dbus_rsrc = PC; o.dbus_rdst = LR; push(o, rnd());
            o = '0; o.alu_en = 1; o.sxt_en = 1; o.sxt_bit = 4'd13; o.alu_rdst = PC;
            o.psw_update = 1; o.instr_done = 1; push(o, rnd());
        end else if (opi >= 1 && opi <= 8) begin
            if (t.cr) begin
                o.alu_en = 1; o.sxt_en = 1; o.sxt_bit = 4'd10; o.alu_rdst = PC; o.psw_update = 1;
            end
            o.instr_done = 1; push(o, rnd());
        end else if (k >= 0) begin
            o.alu_en = 1; o.alu_op = 6'(k * 2 + int'(t.wb)); o.alu_rdst = d;
            o.alu_rsrc = src_of(t); o.instr_done = 1; push(o, rnd());
        end else if (opi == 21) begin
            o.dbus_rsrc = src_of(t); o.dbus_rdst = d; o.instr_done = 1; push(o, rnd());
        end else if (opi == 22) begin
            o.dbus_rsrc = src_of(t); o.dbus_rdst = TMP; push(o, rnd());
            o = '0; o.dbus_rsrc = TMP; o.dbus_rdst = d; o.instr_done = 1; push(o, rnd());
        end else if (opi == 25 || (opi >= 34 && opi <= 37)) begin
            o.bm_en = 1; o.dbus_rsrc = src_of(t); o.dbus_rdst = d; o.instr_done = 1;
            push(o, rnd());
        end else if (opi == 26) begin
            o.sxt_en = 1; o.sxt_bit = 4'd7; o.dbus_rsrc = d; o.dbus_rdst = d;
            o.instr_done = 1; push(o, rnd());
        end else if (opi == 29 || opi == 30) begin
            o.psw_set = (opi == 29); o.psw_clr = (opi == 30); o.instr_done = 1; push(o, rnd());
        end else if (opi == 32 || opi == 33 || opi == 38 || opi == 39) begin
            o.alu_en = 1; o.alu_rdst = TMP; o.alu_rsrc = st ? d : src_of(t); o.psw_update = 1;
            if (opi >= 38) begin o.sxt_en = 1; o.sxt_bit = 4'd6; end
            push(o, rnd());
            for (int i = 0; i <= mw; i++) begin
                o = '0; o.mem_req = 1; o.mem_wr = st; o.mem_byte = t.wb;
                if (st) o.dbus_rsrc = src_of(t);
                if (i == mw) begin
                    o.instr_done = 1;
                    if (!st) o.dbus_rdst = d;
                end
                push(o, i == mw);
            end
        end else begin
            o.instr_done = 1; push(o, rnd());
        end
    endtask

    task automatic apply(input instr_t t);
        op = t.op; dst = t.dst; srccon = t.src; rc = t.rc; wb = t.wb; code_result = t.cr;
    endtask

    // Called #1 after a rising edge with the sequencer in FETCH.
    task automatic run_expected(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ack = ack_q[i];
            @(negedge clock);
            check_outs(name, snap(), exp_q[i]);
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    len = 0;
        bit    done = 0;
        outs_t last = '0;
        apply(v.ins);
        mem_ack = 1'b1;
        while (!done && len < 20) begin
            @(negedge clock);
            len++;
            if (instr_done) begin last = snap(); done = 1; end
            @(posedge clock); #1;
        end
        check_bits($sformatf("vec%0d_len", idx), 64'(len), 64'(v.len));
        check_bits($sformatf("vec%0d_fields", idx),
                   64'({last.alu_en, last.alu_op, last.sxt_bit, last.dbus_rdst, last.mem_wr}),
                   64'({v.alu_en, v.alu_op, v.sxt_bit, v.dbus_rdst, v.mem_wr}));
    endtask

    task automatic add_vec(input logic [6:0] o, input logic [2:0] d, input logic [2:0] s,
                           input logic w, input logic c, input int len, input logic ae,
                           input logic [5:0] ao, input logic [3:0] sb, input logic [4:0] dr,
                           input logic mw);
        vec_t v;
        v.ins = '{op: o, dst: d, src: s, rc: 1'b0, wb: w, cr: c};
        v.len = len; v.alu_en = ae; v.alu_op = ao; v.sxt_bit = sb; v.dbus_rdst = dr;
        v.mem_wr = mw;
        vecs.push_back(v);
    endtask

    initial begin
        instr_t t;
        outs_t  o;
        int     reqcnt, donec, wrseen, badwait, badfault;

        reset = 1'b1; mem_ack = 1'b0;
        op = '0; dst = '0; srccon = '0; rc = 1'b0; wb = 1'b0; code_result = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_outs("reset_outputs", snap(), '0);
        reset = 1'b0;

        //        op  dst  src  wb  cr  len alu_en alu_op sxt dbus_rdst mem_wr
        add_vec(7'd9,  3'd2, 3'd3, 1, 0, 4, 1, 6'd1,  4'd0,  5'd0, 0); // ADD.B
        add_vec(7'd1,  3'd0, 3'd0, 0, 0, 4, 0, 6'd0,  4'd0,  5'd0, 0); // branch not taken
        add_vec(7'd1,  3'd0, 3'd0, 0, 1, 4, 1, 6'd0,  4'd10, 5'd0, 0); // branch taken
        add_vec(7'd21, 3'd5, 3'd6, 0, 0, 4, 0, 6'd0,  4'd0,  5'd5, 0); // MOV
        add_vec(7'd22, 3'd1, 3'd4, 0, 0, 5, 0, 6'd0,  4'd0,  5'd1, 0); // SWAP
        add_vec(7'd0,  3'd0, 3'd0, 0, 0, 5, 1, 6'd0,  4'd13, 5'd0, 0); // BL
        add_vec(7'd11, 3'd3, 3'd1, 0, 0, 4, 1, 6'd4,  4'd0,  5'd0, 0); // SUB.W
        add_vec(7'd24, 3'd3, 3'd1, 1, 0, 4, 1, 6'd27, 4'd0,  5'd0, 0); // op 24 byte
        add_vec(7'd32, 3'd2, 3'd3, 0, 0, 5, 0, 6'd0,  4'd0,  5'd2, 0); // LD
        add_vec(7'd39, 3'd2, 3'd3, 1, 0, 5, 0, 6'd0,  4'd0,  5'd0, 1); // STR
        add_vec(7'd40, 3'd0, 3'd0, 0, 0, 4, 0, 6'd0,  4'd0,  5'd0, 0); // out of range no-op
        add_vec(7'd29, 3'd0, 3'd0, 0, 0, 4, 0, 6'd0,  4'd0,  5'd0, 0); // SETCC
        add_vec(7'd26, 3'd4, 3'd0, 0, 0, 4, 0, 6'd0,  4'd7,  5'd4, 0); // SXT
        @(posedge clock); #1;
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Randomized instructions with random memory wait states.
        for (int n = 0; n < 150; n++) begin
            t.op = 7'($urandom_range(0, 45));
            t.dst = 3'($urandom); t.src = 3'($urandom);
            t.rc = 1'($urandom); t.wb = 1'($urandom); t.cr = 1'($urandom);
            apply(t);
            build(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            run_expected($sformatf("rand%0d_op%0d", n, t.op));
        end

        // Reset asserted while a load waits in MEMW.
        t = '{op: 7'd32, dst: 3'd2, src: 3'd3, rc: 1'b0, wb: 1'b0, cr: 1'b0};
        apply(t);
        mem_ack = 1'b1;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        check_bits("memw_req_waiting", 64'(mem_req), 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_outs("reset_mid_memw", snap(), '0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_outs("fetch_after_reset", snap(), fetch_o(1'b0));
        @(posedge clock); #1;

        // LDR with three memory wait cycles.
        t = '{op: 7'd38, dst: 3'd1, src: 3'd2, rc: 1'b0, wb: 1'b0, cr: 1'b0};
        apply(t);
        reqcnt = 0; donec = -1; wrseen = 0;
        for (int c = 0; c < 20; c++) begin
            mem_ack = (c == 0 || c == 7);
            @(negedge clock);
            if (c >= 1 && mem_req) reqcnt++;
            if (mem_wr) wrseen = 1;
            if (instr_done) begin
                donec = c;
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
        check_bits("ldr_req_cycles", 64'(reqcnt), 64'd4);
        check_bits("ldr_done_cycle", 64'(donec), 64'd7);
        check_bits("ldr_mem_wr", 64'(wrseen), 64'd0);

        // Memory never answers the fetch: fault after 15 waiting cycles.
        t = '{op: 7'd21, dst: 3'd1, src: 3'd2, rc: 1'b0, wb: 1'b0, cr: 1'b0};
        apply(t);
        badwait = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clock);
            if (!mem_req || fault) badwait++;
            @(posedge clock); #1;
        end
        check_bits("timeout_wait_cycles", 64'(badwait), 64'd0);
        @(negedge clock);
        o = '0; o.fault = 1'b1;
        check_outs("timeout_fault", snap(), o);
        badfault = 0;
        mem_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            mem_ack = ~mem_ack;
            @(negedge clock);
            if (snap() !== o) badfault++;
        end
        check_bits("fault_sticky", 64'(badfault), 64'd0);
        mem_ack = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_outs("fault_cleared_by_reset", snap(), fetch_o(1'b0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
